inst_fetcher: RTL and testbench

Instruction fetch stage with a small in-order instruction queue. It holds the fetch PC and issues one 32-bit instruction read at a time to the memory controller. Returned words, tagged with their PC, are buffered in a circular queue. The queue head is presented to the decode stage, which decodes `inst` into op_type/rs1/rs2/rd/imm. A backend redirect (jump, branch resolution) flushes the queue, discards any in-flight read and restarts fetch at the new PC.

---
 rtl/inst_fetcher.sv | 171 +++++++++++++++++
 tb/tb_inst_fetcher.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// inst_fetcher
//
// Instruction fetch stage. Holds the fetch PC and keeps at most one 32-bit
// read outstanding to the memory controller. Each returned word is stored
// with its PC in a small circular queue. The head of the queue is offered
// to decode. A backend redirect flushes the queue, drops any in-flight read
// and restarts fetch at the new PC.
//
// Parameters
//   QUEUE_DEPTH_LOG  log2 of the queue depth (default 2 -> 4 entries)
//   RESET_PC         fetch PC after reset
//
// Ports
//   clk_in          in   clock, rising edge
//   rst_in          in   asynchronous active-high reset
//   rdy_in          in   global enable; low freezes every register
//   mem_req_valid   out  read request pending (registered)
//   mem_req_addr    out  byte address of the pending read (registered)
//   mem_resp_valid  in   one-cycle pulse, mem_resp_inst holds the word
//   mem_resp_inst   in   returned instruction word
//   redirect_valid  in   flush and restart fetch at redirect_pc
//   redirect_pc     in   new fetch PC (4-byte aligned)
//   inst_valid      out  queue head valid (combinational)
//   inst            out  queue head instruction
//   inst_pc         out  PC of the queue head instruction
//   inst_ready      in   decode accepts the head this cycle
module inst_fetcher #(
  parameter int          QUEUE_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

  typedef logic [QUEUE_DEPTH_LOG-1:0] ptr_t;
  typedef logic [QUEUE_DEPTH_LOG:0]   cnt_t;

  // Full-queue count value, built without a truncating integer assignment.
  localparam cnt_t DEPTH_CNT = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no read outstanding
    BUSY    = 2'd1,  // read outstanding, word will be enqueued
    DISCARD = 2'd2   // read outstanding, word will be dropped
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;
  logic [31:0] q_inst [DEPTH];
  logic [31:0] q_pc   [DEPTH];

  logic push;
  logic pop;

  // Pointers wrap naturally at the queue depth.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

  // The head is hidden during a redirect so decode never consumes an entry
  // that is being flushed on the same edge.
  assign inst_valid = (count != '0) && !redirect_valid;
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];

  // The request address is still held on mem_req_addr in the response
  // cycle, so it doubles as the PC tag of the returned word.
  assign push = (state == BUSY) && mem_resp_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (redirect_valid) begin
        // Flush wins over any push or pop on this edge.
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
        case (state)
          IDLE: state <= IDLE;
          BUSY: begin
            if (mem_resp_valid) begin
              mem_req_valid <= 1'b0;
              state         <= IDLE;
            end else begin
              // Request stays on the bus until its response drains.
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (mem_resp_valid) begin
              mem_req_valid <= 1'b0;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        if (push) begin
          q_inst[tail] <= mem_resp_inst;
          q_pc[tail]   <= mem_req_addr;
          tail         <= ptr_inc(tail);
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
        if (push && !pop) begin
          count <= count + cnt_t'(1);
        end else if (!push && pop) begin
          count <= count - cnt_t'(1);
        end

        case (state)
          IDLE: begin
            // Issuing only below full guarantees room for the response,
            // since count cannot grow while the read is outstanding.
            if (count < DEPTH_CNT) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= fetch_pc;
              state         <= BUSY;
            end
          end
          BUSY: begin
            if (mem_resp_valid) begin
              fetch_pc      <= fetch_pc + 32'd4;
              mem_req_valid <= 1'b0;
              state         <= IDLE;
            end
          end
          DISCARD: begin
            // fetch_pc already holds the redirect target; do not advance.
            if (mem_resp_valid) begin
              mem_req_valid <= 1'b0;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Testbench for inst_fetcher: memory responder with programmable latency,
// queue scoreboard, a table of per-cycle vectors for the basic fetch
// sequence and hand-written sequences for the multi-cycle corner cases.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(
    .QUEUE_DEPTH_LOG(2),
    .RESET_PC       (32'h0)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_inst (mem_resp_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t exp_q[$];

  // Memory responder / scoreboard state
  int          mem_lat;
  logic        mdl_busy;
  int          mdl_w;
  logic        mdl_discard;
  logic        force_resp;
  logic        seq_on;
  logic [31:0] seq_pc;
  int          n_pop;

  typedef struct {
    logic        ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00000013;
    if (a == 32'h4) return 32'h00100093;
    return a ^ 32'h5A5A0003;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive the memory response, check the head against the
  // scoreboard, update the scoreboard, advance to just after the next edge.
  task automatic cycle();
    ent_t e;
    mem_resp_valid = 1'b0;
    mem_resp_inst  = 32'h0;
    if (rdy_in) begin
      if (force_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_inst  = 32'hDEADBEEF;
      end else begin
        if (!mdl_busy && mem_req_valid) begin
          mdl_busy = 1'b1;
          mdl_w    = mem_lat;
        end
        if (mdl_busy) begin
          if (mdl_w == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_inst  = mem_word(mem_req_addr);
            mdl_busy       = 1'b0;
          end else begin
            mdl_w--;
          end
        end
      end
    end
    #1;
    chk1("inst_valid", inst_valid, (exp_q.size() != 0) && !redirect_valid);
    if (rdy_in && !redirect_valid && inst_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk32("head_inst", inst, e.inst);
      chk32("head_pc", inst_pc, e.pc);
      if (seq_on) begin
        chk32("pop_order", inst_pc, seq_pc);
        seq_pc = seq_pc + 32'd4;
      end
      n_pop++;
    end
    if (rdy_in) begin
      if (mem_resp_valid && !force_resp) begin
        if (!redirect_valid && !mdl_discard) begin
          e.inst = mem_resp_inst;
          e.pc   = mem_req_addr;
          exp_q.push_back(e);
        end
        mdl_discard = 1'b0;
      end
      if (redirect_valid) begin
        exp_q.delete();
        if (mdl_busy) mdl_discard = 1'b1;
      end
    end
    @(posedge clk_in);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_inst  = 32'h0;
    force_resp     = 1'b0;
  endtask

  task automatic do_reset();
    rst_in         = 1'b1;
    rdy_in         = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_inst  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    force_resp     = 1'b0;
    mdl_busy       = 1'b0;
    mdl_w          = 0;
    mdl_discard    = 1'b0;
    exp_q.delete();
    seq_on         = 1'b1;
    seq_pc         = 32'h0;
    n_pop          = 0;
    #1;
    chk1 ("rst_req_valid", mem_req_valid, 1'b0);
    chk32("rst_req_addr", mem_req_addr, 32'h0);
    chk1 ("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h00000013, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h00000013, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h00000013, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h00000013, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h00000013, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h00100093, 32'h4};

    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_inst  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    force_resp     = 1'b0;
    mem_lat        = 3;
    @(posedge clk_in);
    #1;

    // Reset, then sequential fetch with 3-cycle memory
    do_reset();
    mem_lat = 3;
    for (int i = 0; i < 12; i++) begin
      inst_ready = vecs[i].ready;
      chk1 ($sformatf("seq_req_valid[%0d]", i), mem_req_valid, vecs[i].exp_req_valid);
      chk32($sformatf("seq_req_addr[%0d]", i), mem_req_addr, vecs[i].exp_req_addr);
      chk1 ($sformatf("seq_inst_valid[%0d]", i), inst_valid, vecs[i].exp_inst_valid);
      chk32($sformatf("seq_inst[%0d]", i), inst, vecs[i].exp_inst);
      chk32($sformatf("seq_inst_pc[%0d]", i), inst_pc, vecs[i].exp_pc);
      cycle();
    end
    inst_ready = 1'b0;

    // Queue full with 0-latency memory
    do_reset();
    mem_lat = 0;
    repeat (16) cycle();
    for (int i = 0; i < 5; i++) begin
      chk1 ("full_no_req", mem_req_valid, 1'b0);
      chk32("full_head_pc", inst_pc, 32'h0);
      cycle();
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    chk1("full_pop_idle", mem_req_valid, 1'b0);
    cycle();
    chk1 ("refill_req_valid", mem_req_valid, 1'b1);
    chk32("refill_req_addr", mem_req_addr, 32'h10);
    inst_ready = 1'b1;
    for (int n = 0; n < 60 && n_pop < 5; n++) cycle();
    inst_ready = 1'b0;
    chk1("full_drain", n_pop >= 5, 1'b1);

    // Wrap-around with random decode backpressure
    do_reset();
    mem_lat = 1;
    for (int n = 0; n < 400 && n_pop < 10; n++) begin
      inst_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    inst_ready = 1'b0;
    chk1("wrap_ten_pops", n_pop == 10, 1'b1);

    // Redirect while the read to 0x8 is outstanding
    do_reset();
    mem_lat = 4;
    for (int n = 0; n < 100 && !(mem_req_valid && mem_req_addr == 32'h8); n++) cycle();
    chk1("busy_req8_seen", mem_req_valid && mem_req_addr == 32'h8, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1000;
    cycle();
    redirect_valid = 1'b0;
    seq_pc         = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      chk1 ("discard_hold_valid", mem_req_valid, 1'b1);
      chk32("discard_hold_addr", mem_req_addr, 32'h8);
      cycle();
    end
    chk1("discard_idle", mem_req_valid, 1'b0);
    chk1("discard_no_word", inst_valid, 1'b0);
    cycle();
    chk1 ("redir_req_valid", mem_req_valid, 1'b1);
    chk32("redir_req_addr", mem_req_addr, 32'h1000);
    inst_ready = 1'b1;
    for (int n = 0; n < 40 && n_pop < 1; n++) cycle();
    inst_ready = 1'b0;
    chk1("redir_first_pop", n_pop >= 1, 1'b1);

    // Redirect coincident with a response and a pop, 2 entries queued
    do_reset();
    mem_lat = 2;
    for (int n = 0; n < 100 && !(exp_q.size() == 2 && mdl_busy && mdl_w == 0); n++) cycle();
    chk1("coinc_setup", exp_q.size() == 2 && mdl_busy && mdl_w == 0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    inst_ready     = 1'b1;
    #1;
    chk1("coinc_inst_valid", inst_valid, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    seq_pc         = 32'h200;
    chk1("coinc_empty", inst_valid, 1'b0);
    chk1("coinc_idle", mem_req_valid, 1'b0);
    cycle();
    chk1 ("coinc_req_valid", mem_req_valid, 1'b1);
    chk32("coinc_req_addr", mem_req_addr, 32'h200);

    // rdy_in low for 5 cycles with a request pending
    do_reset();
    mem_lat = 3;
    for (int n = 0; n < 100 && !(exp_q.size() == 1 && mem_req_valid); n++) cycle();
    chk1("rdy_setup", exp_q.size() == 1 && mem_req_valid, 1'b1);
    rdy_in     = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1 ("rdy_req_valid", mem_req_valid, 1'b1);
      chk32("rdy_req_addr", mem_req_addr, 32'h4);
      chk1 ("rdy_inst_valid", inst_valid, 1'b1);
      chk32("rdy_inst", inst, 32'h00000013);
      chk32("rdy_inst_pc", inst_pc, 32'h0);
    end
    rdy_in = 1'b1;
    for (int n = 0; n < 100 && n_pop < 4; n++) cycle();
    inst_ready = 1'b0;
    chk1("rdy_resume", n_pop >= 4, 1'b1);

    // Reset mid-read, then a stray response while IDLE
    for (int n = 0; n < 20 && !mem_req_valid; n++) cycle();
    chk1("midread_req", mem_req_valid, 1'b1);
    do_reset();
    mem_lat    = 1;
    force_resp = 1'b1;
    cycle();
    chk1 ("stray_inst_valid", inst_valid, 1'b0);
    chk1 ("stray_req_valid", mem_req_valid, 1'b1);
    chk32("stray_req_addr", mem_req_addr, 32'h0);
    inst_ready = 1'b1;
    for (int n = 0; n < 40 && n_pop < 2; n++) cycle();
    inst_ready = 1'b0;
    chk1("stray_resume", n_pop >= 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
